upbus_arb: RTL and testbench

- N-port round-robin arbiter and sequencer for the shared microprocessor register bus (upa/updo/updi, upws/uprs/uprdy).
- Each requester (CPU bridge, debug/JTAG port, init sequencer, etc.) presents a level-held read or write request. The arbiter grants one requester at a time and issues a single-cycle strobe.
- It waits for uprdy or a timeout, then returns read data and a one-cycle done pulse to the granted requester.
- Sits between the bus-side strobe generators and the register-file decode.

---
 rtl/upbus_pkg.sv | 24 ++
 rtl/rr_pick.sv | 36 +++
 rtl/upbus_arb.sv | 160 ++++++++++++++++
 tb/tb_upbus_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/upbus_pkg.sv
// Shared definitions for the microprocessor register-bus arbiter: state encoding,
// default timeout read data and a width helper.
package upbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } upbus_state_e;

    localparam logic [31:0] ERRDAT_DEFAULT = 32'hDEAD_C0DE;

    // Bits needed to index 'value' distinct items; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first set request at or after ptr,
// wrapping modulo N, and reports it both one-hot and as an index.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    int   best_s;
    int   dist_s;
    logic take_s;

    // Keep the requester with the smallest circular distance from ptr.
    always_comb begin
        best_s = N;
        dist_s = 0;
        take_s = 1'b0;
        idx    = '0;
        for (int j = 0; j < N; j++) begin
            dist_s = (j + N - int'(ptr)) % N;
            take_s = req[j] && (dist_s < best_s);
            idx    = take_s ? PW'(j) : idx;
            best_s = take_s ? dist_s : best_s;
        end
        any = (best_s < N);
        gnt = any ? (ONE << idx) : '0;
    end

endmodule

// File: rtl/upbus_arb.sv
// Round-robin arbiter and sequencer for the shared register bus: grants one
// requester, issues a one-cycle strobe, waits for uprdy or timeout, reports done.
module upbus_arb
    import upbus_pkg::*;
#(
    parameter int          NREQ   = 2,
    parameter int          AW     = 16,
    parameter int          DW     = 32,
    parameter int          TOUT   = 255,
    parameter logic [31:0] ERRDAT = ERRDAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdat,
    output logic [NREQ-1:0]    req_done,
    output logic               req_err,
    output logic [DW-1:0]      req_rdat,
    output logic [AW-1:0]      upa,
    output logic [DW-1:0]      updo,
    output logic               upws,
    output logic               uprs,
    output logic               upen,
    input  logic [DW-1:0]      updi,
    input  logic               uprdy
);

    localparam int PW = clog2(NREQ);
    localparam int CW = clog2(TOUT + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]   ERR_DW   = DW'(ERRDAT);

    upbus_state_e    state_r;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   grant_idx_r;
    logic            op_wr_r;
    logic [CW-1:0]   cnt_r;

    logic [NREQ-1:0] active_s;
    logic [NREQ-1:0] pick_gnt_s;
    logic [PW-1:0]   pick_idx_s;
    logic            pick_any_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdat_s;
    logic            sel_wr_s;

    assign active_s = req_wr | req_rd;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req (active_s),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Mux out the winning port's address, data and operation (write wins over read).
    always_comb begin
        sel_addr_s = '0;
        sel_wdat_s = '0;
        sel_wr_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s = pick_gnt_s[i] ? req_addr[i*AW +: AW] : sel_addr_s;
            sel_wdat_s = pick_gnt_s[i] ? req_wdat[i*DW +: DW] : sel_wdat_s;
            sel_wr_s   = pick_gnt_s[i] ? req_wr[i]            : sel_wr_s;
        end
    end

    // Access sequencer; every bus and requester output is a register of this FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            grant_idx_r <= '0;
            op_wr_r     <= 1'b0;
            cnt_r       <= '0;
            upa         <= '0;
            updo        <= '0;
            upws        <= 1'b0;
            uprs        <= 1'b0;
            upen        <= 1'b0;
            req_done    <= '0;
            req_err     <= 1'b0;
            req_rdat    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_done <= '0;
                    req_err  <= 1'b0;
                    req_rdat <= '0;
                    if (pick_any_s) begin
                        grant_idx_r <= pick_idx_s;
                        op_wr_r     <= sel_wr_s;
                        upa         <= sel_addr_s;
                        updo        <= sel_wdat_s;
                        upws        <= sel_wr_s;
                        uprs        <= ~sel_wr_s;
                        upen        <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    upws  <= 1'b0;
                    uprs  <= 1'b0;
                    cnt_r <= CW'(TOUT);
                    if (uprdy) begin
                        req_done <= ONE_HOT0 << grant_idx_r;
                        req_err  <= 1'b0;
                        req_rdat <= op_wr_r ? '0 : updi;
                        upen     <= 1'b0;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A late uprdy on the last counted cycle still wins over the abort.
                    if (uprdy) begin
                        req_done <= ONE_HOT0 << grant_idx_r;
                        req_err  <= 1'b0;
                        req_rdat <= op_wr_r ? '0 : updi;
                        upen     <= 1'b0;
                        state_r  <= ST_DONE;
                    end else if (cnt_r == CW'(1)) begin
                        req_done <= ONE_HOT0 << grant_idx_r;
                        req_err  <= 1'b1;
                        req_rdat <= op_wr_r ? '0 : ERR_DW;
                        upen     <= 1'b0;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r    <= cnt_r - CW'(1);
                        state_r  <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    req_done <= '0;
                    req_err  <= 1'b0;
                    req_rdat <= '0;
                    ptr_r    <= (grant_idx_r == PW'(NREQ - 1)) ? '0 : grant_idx_r + PW'(1);
                    state_r  <= ST_IDLE;
                end
                default: begin
                    upws     <= 1'b0;
                    uprs     <= 1'b0;
                    upen     <= 1'b0;
                    req_done <= '0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upbus_arb.sv
// Directed bench for upbus_arb (4 ports, short timeout): per-cycle vector table
// plus hand sequences for reset-mid-access and round-robin fairness.
module tb_upbus_arb;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_wr;
    logic [3:0]   req_rd;
    logic [63:0]  req_addr;
    logic [127:0] req_wdat;
    logic [3:0]   req_done;
    logic         req_err;
    logic [31:0]  req_rdat;
    logic [15:0]  upa;
    logic [31:0]  updo;
    logic         upws;
    logic         uprs;
    logic         upen;
    logic [31:0]  updi;
    logic         uprdy;
    logic [87:0]  obs;

    upbus_arb #(
        .NREQ   (4),
        .AW     (16),
        .DW     (32),
        .TOUT   (4),
        .ERRDAT (32'hDEAD_C0DE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_wr   (req_wr),
        .req_rd   (req_rd),
        .req_addr (req_addr),
        .req_wdat (req_wdat),
        .req_done (req_done),
        .req_err  (req_err),
        .req_rdat (req_rdat),
        .upa      (upa),
        .updo     (updo),
        .upws     (upws),
        .uprs     (uprs),
        .upen     (upen),
        .updi     (updi),
        .uprdy    (uprdy)
    );

    assign obs = {upws, uprs, upen, req_done, req_err, req_rdat, upa, updo};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  wr;
        logic [3:0]  rd;
        logic        rdy;
        logic [31:0] di;
        logic [87:0] exp;
    } vec_t;

    vec_t tv[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic row(input string name, input logic rst, input logic [3:0] wr, input logic [3:0] rd,
                       input logic rdy, input logic [31:0] di, input logic ws, input logic rs,
                       input logic en, input logic [3:0] done, input logic err, input logic [31:0] rdat,
                       input logic [15:0] a, input logic [31:0] d);
        vec_t v;
        v.name = name; v.rst = rst; v.wr = wr; v.rd = rd; v.rdy = rdy; v.di = di;
        v.exp  = {ws, rs, en, done, err, rdat, a, d};
        tv.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int grants[8];
        int times[8];
        int ns;
        int round;

        rst_n    = 1'b0;
        req_wr   = 4'b0;
        req_rd   = 4'b0;
        uprdy    = 1'b0;
        updi     = 32'h0;
        req_addr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        req_wdat = {32'h3333_3333, 32'h0000_2222, 32'hCAFE_0001, 32'h1234_5678};

        //   name         rst wr    rd    rdy di              ws rs en done   err rdat            upa       updo
        row("rst0",      0, 4'h0, 4'h0, 0, 32'h0,         0, 0, 0, 4'h0, 0, 32'h0,         16'h0000, 32'h0);
        row("rst1",      0, 4'h0, 4'h0, 1, 32'h0,         0, 0, 0, 4'h0, 0, 32'h0,         16'h0000, 32'h0);
        row("wr_issue",  1, 4'h1, 4'h0, 0, 32'h0,         1, 0, 1, 4'h0, 0, 32'h0,         16'h0010, 32'h1234_5678);
        row("wr_wait0",  1, 4'h1, 4'h0, 0, 32'h0,         0, 0, 1, 4'h0, 0, 32'h0,         16'h0010, 32'h1234_5678);
        row("wr_wait1",  1, 4'h1, 4'h0, 0, 32'h0,         0, 0, 1, 4'h0, 0, 32'h0,         16'h0010, 32'h1234_5678);
        row("wr_done",   1, 4'h1, 4'h0, 1, 32'h0,         0, 0, 0, 4'h1, 0, 32'h0,         16'h0010, 32'h1234_5678);
        row("wr_idle",   1, 4'h0, 4'h0, 0, 32'h0,         0, 0, 0, 4'h0, 0, 32'h0,         16'h0010, 32'h1234_5678);
        row("rd_issue",  1, 4'h0, 4'h2, 0, 32'h0,         0, 1, 1, 4'h0, 0, 32'h0,         16'h0020, 32'hCAFE_0001);
        row("rd_done",   1, 4'h0, 4'h2, 1, 32'hA5A5_0001, 0, 0, 0, 4'h2, 0, 32'hA5A5_0001, 16'h0020, 32'hCAFE_0001);
        row("rd_idle",   1, 4'h0, 4'h0, 0, 32'h0,         0, 0, 0, 4'h0, 0, 32'h0,         16'h0020, 32'hCAFE_0001);
        row("to_issue",  1, 4'h0, 4'h4, 0, 32'h0,         0, 1, 1, 4'h0, 0, 32'h0,         16'h0030, 32'h0000_2222);
        for (int k = 0; k < 4; k++)
            row("to_wait", 1, 4'h0, 4'h4, 0, 32'h0,       0, 0, 1, 4'h0, 0, 32'h0,         16'h0030, 32'h0000_2222);
        row("to_done",   1, 4'h0, 4'h4, 0, 32'h0,         0, 0, 0, 4'h4, 1, 32'hDEAD_C0DE, 16'h0030, 32'h0000_2222);
        row("to_idle",   1, 4'h0, 4'h0, 0, 32'h0,         0, 0, 0, 4'h0, 0, 32'h0,         16'h0030, 32'h0000_2222);
        row("p3_issue",  1, 4'h8, 4'h0, 0, 32'h0,         1, 0, 1, 4'h0, 0, 32'h0,         16'h0040, 32'h3333_3333);
        row("p3_done",   1, 4'h8, 4'h0, 1, 32'h7777_7777, 0, 0, 0, 4'h8, 0, 32'h0,         16'h0040, 32'h3333_3333);
        row("p3_idle",   1, 4'h0, 4'h0, 0, 32'h0,         0, 0, 0, 4'h0, 0, 32'h0,         16'h0040, 32'h3333_3333);
        row("tb_issue",  1, 4'h0, 4'h1, 0, 32'h0,         0, 1, 1, 4'h0, 0, 32'h0,         16'h0010, 32'h1234_5678);
        for (int k = 0; k < 4; k++)
            row("tb_wait", 1, 4'h0, 4'h1, 0, 32'h0,       0, 0, 1, 4'h0, 0, 32'h0,         16'h0010, 32'h1234_5678);
        row("tb_done",   1, 4'h0, 4'h1, 1, 32'h0BAD_F00D, 0, 0, 0, 4'h1, 0, 32'h0BAD_F00D, 16'h0010, 32'h1234_5678);
        row("tb_idle",   1, 4'h0, 4'h0, 0, 32'h0,         0, 0, 0, 4'h0, 0, 32'h0,         16'h0010, 32'h1234_5678);
        row("wp_issue",  1, 4'h2, 4'h2, 0, 32'h0,         1, 0, 1, 4'h0, 0, 32'h0,         16'h0020, 32'hCAFE_0001);
        row("wp_done",   1, 4'h2, 4'h2, 1, 32'hFFFF_FFFF, 0, 0, 0, 4'h2, 0, 32'h0,         16'h0020, 32'hCAFE_0001);
        row("wp_idle",   1, 4'h0, 4'h0, 0, 32'h0,         0, 0, 0, 4'h0, 0, 32'h0,         16'h0020, 32'hCAFE_0001);
        row("rdy_idle",  1, 4'h0, 4'h0, 1, 32'h1234_1234, 0, 0, 0, 4'h0, 0, 32'h0,         16'h0020, 32'hCAFE_0001);

        foreach (tv[i]) begin
            rst_n  = tv[i].rst;
            req_wr = tv[i].wr;
            req_rd = tv[i].rd;
            uprdy  = tv[i].rdy;
            updi   = tv[i].di;
            step();
            check(tv[i].name, obs, tv[i].exp);
        end

        // Abandon a read in WAIT with reset; pointer was left at 2 by the table.
        rst_n  = 1'b1;
        req_rd = 4'b0010;
        uprdy  = 1'b0;
        step();
        step();
        step();
        check("mid_busy", {87'b0, upen}, 88'd1);
        rst_n  = 1'b0;
        req_rd = 4'b0;
        uprdy  = 1'b1;
        step();
        check("rst_mid", obs, 88'd0);

        // All four ports read with uprdy stuck high; re-assert after the first round.
        rst_n  = 1'b1;
        req_rd = 4'hF;
        updi   = 32'h1111_0000;
        ns     = 0;
        round  = 0;
        for (int c = 0; c < 60 && ns < 8; c++) begin
            step();
            if (uprs) begin
                grants[ns] = int'(upa[7:4]) - 1;
                times[ns]  = c;
                ns++;
            end
            if (req_done != 4'b0) begin
                check("rr_rdat", {56'b0, req_rdat}, {56'b0, 32'h1111_0000});
                req_rd = req_rd & ~req_done;
                if (req_rd == 4'b0 && round == 0) begin
                    req_rd = 4'hF;
                    round  = 1;
                end
            end
        end
        check("rr_count", 88'(ns), 88'd8);
        for (int k = 0; k < ns; k++) begin
            check("rr_grant", 88'(grants[k]), 88'(k % 4));
            if (k > 0) check("rr_spacing", 88'(times[k] - times[k-1]), 88'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
